// File: rtl/fair_req_arbiter.sv
// Two-requester round-robin arbiter with a hold limit that preempts an owner
// who keeps the resource too long while the other side is waiting.
//
// state | meaning
// IDLE  | no owner; arbitrate between reqA/reqB using prio
// OWN_A | A holds the resource (grantA=1)
// OWN_B | B holds the resource (grantB=1)
module fair_req_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic reqA,
    input  logic reqB,
    input  logic doneA,
    input  logic doneB,
    output logic grantA,
    output logic grantB,
    output logic prio,
    output logic preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] hold_inc;
    logic       prio_q, prio_d;
    logic       preempt_q, preempt_d;
    logic       grant_a_q, grant_b_q;

    // Saturating increment so the counter can never wrap back to zero.
    assign hold_inc = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        prio_d    = prio_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqA && (!reqB || !prio_q)) begin
                    state_d = OWN_A;
                    prio_d  = 1'b1;
                    hold_d  = 4'd0;
                end else if (reqB) begin
                    state_d = OWN_B;
                    prio_d  = 1'b0;
                    hold_d  = 4'd0;
                end
            end
            OWN_A: begin
                // A release beats the hold limit, so no preempt in that case.
                if (doneA || !reqA) begin
                    state_d = IDLE;
                    hold_d  = 4'd0;
                end else if (reqB) begin
                    hold_d = hold_inc;
                    if (hold_inc >= HOLD_LIM) begin
                        state_d   = IDLE;
                        preempt_d = 1'b1;
                    end
                end
            end
            OWN_B: begin
                if (doneB || !reqB) begin
                    state_d = IDLE;
                    hold_d  = 4'd0;
                end else if (reqA) begin
                    hold_d = hold_inc;
                    if (hold_inc >= HOLD_LIM) begin
                        state_d   = IDLE;
                        preempt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            hold_q    <= 4'd0;
            prio_q    <= 1'b0;
            preempt_q <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            prio_q    <= prio_d;
            preempt_q <= preempt_d;
            grant_a_q <= (state_d == OWN_A);
            grant_b_q <= (state_d == OWN_B);
        end
    end

    assign grantA  = grant_a_q;
    assign grantB  = grant_b_q;
    assign prio    = prio_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_fair_req_arbiter.sv
// Bench for fair_req_arbiter: directed scenarios then random traffic, all
// compared cycle by cycle against a behavioural ownership model.
module tb_fair_req_arbiter;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reqA = 1'b0, reqB = 1'b0, doneA = 1'b0, doneB = 1'b0;
    logic grantA, grantB, prio, preempt;

    fair_req_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset),
        .reqA(reqA), .reqB(reqB), .doneA(doneA), .doneB(doneB),
        .grantA(grantA), .grantB(grantB), .prio(prio), .preempt(preempt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Model: who owns the resource (0 none, 1 A, 2 B), whose turn a tie is,
    // how many cycles the owner has kept it against a waiting rival.
    int owner = 0;
    bit m_prio = 0;
    int m_held = 0;
    bit m_pre = 0;
    bit pre_prev = 0;
    int wait_a = 0, wait_b = 0;

    task automatic model_reset();
        owner = 0; m_prio = 0; m_held = 0; m_pre = 0; pre_prev = 0;
        wait_a = 0; wait_b = 0;
    endtask

    task automatic model_edge();
        int  nxt;
        bit  rival;
        bit  released;
        nxt = owner;
        pre_prev = m_pre;
        m_pre = 0;
        if (owner == 0) begin
            if (reqA && reqB) nxt = m_prio ? 2 : 1;
            else if (reqA)    nxt = 1;
            else if (reqB)    nxt = 2;
            if (nxt != 0) begin
                m_prio = (nxt == 1);
                m_held = 0;
            end
        end else begin
            released = (owner == 1) ? (doneA || !reqA) : (doneB || !reqB);
            rival    = (owner == 1) ? reqB : reqA;
            if (released) nxt = 0;
            else if (rival) begin
                m_held++;
                if (m_held >= MH) begin
                    nxt = 0;
                    m_pre = 1;
                end
            end
        end
        wait_a = (reqA && nxt != 1) ? wait_a + 1 : 0;
        wait_b = (reqB && nxt != 2) ? wait_b + 1 : 0;
        owner = nxt;
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".grantA"}, 32'(grantA), 32'(owner == 1));
        check({ctx, ".grantB"}, 32'(grantB), 32'(owner == 2));
        check({ctx, ".prio"}, 32'(prio), 32'(m_prio));
        check({ctx, ".preempt"}, 32'(preempt), 32'(m_pre));
        check({ctx, ".exclusive"}, 32'(grantA & grantB), 32'd0);
        check({ctx, ".pulse1"}, 32'(preempt & pre_prev), 32'd0);
        check({ctx, ".waitA_bound"}, 32'(wait_a <= MH + 2), 32'd1);
        check({ctx, ".waitB_bound"}, 32'(wait_b <= MH + 2), 32'd1);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1 reset = 1'b0;
        #11;
        model_reset();
        compare_all("por");
        @(negedge clk);
        reset = 1'b1;

        // Single requester grant and release.
        reqA = 1'b1;
        step("a_only");
        check("a_only.grant_seen", 32'(grantA), 32'd1);
        doneA = 1'b1;
        step("a_done");
        check("a_done.released", 32'(grantA), 32'd0);
        doneA = 1'b0; reqA = 1'b0;
        step("a_idle");

        // Both requesting, A overstays and gets preempted.
        do_reset();
        reqA = 1'b1; reqB = 1'b1;
        for (int i = 0; i < 7; i++) step("hold_limit");
        check("hold_limit.b_owns", 32'(grantB), 32'd1);
        reqA = 1'b0; reqB = 1'b0;
        step("hold_limit_end");
        step("hold_limit_end");

        // Immediate done: grants alternate with one idle gap.
        reqA = 1'b1; reqB = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step("alternate");
            doneA = grantA;
            doneB = grantB;
        end
        doneA = 1'b0; doneB = 1'b0; reqA = 1'b0; reqB = 1'b0;
        step("alternate_end");

        // Release coinciding with the hold limit is a normal release.
        do_reset();
        reqA = 1'b1; reqB = 1'b1;
        for (int i = 0; i < 4; i++) step("tie_limit");
        doneA = 1'b1;
        step("tie_limit_done");
        check("tie_limit.no_preempt", 32'(preempt), 32'd0);
        check("tie_limit.grantA_off", 32'(grantA), 32'd0);
        doneA = 1'b0; reqA = 1'b0; reqB = 1'b0;
        step("tie_limit_end");

        // Asynchronous reset while B owns.
        do_reset();
        reqB = 1'b1;
        step("own_b");
        check("own_b.grantB", 32'(grantB), 32'd1);
        reset = 1'b0;
        #2;
        check("async_rst.grantB", 32'(grantB), 32'd0);
        model_reset();
        reqA = 1'b1; reqB = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step("post_rst");
        check("post_rst.a_wins", 32'(grantA), 32'd1);
        reqA = 1'b0; reqB = 1'b0;
        step("post_rst_end");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reqA  = ($urandom_range(0, 9) < 7);
            reqB  = ($urandom_range(0, 9) < 7);
            doneA = ($urandom_range(0, 4) == 0);
            doneB = ($urandom_range(0, 4) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fair_req_arbiter.md
FAIR_REQ_ARBITER -- requirements
Module: fair_req_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: max cycles a grant is kept while the other side is requesting; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it low clears all state immediately, independent of clk.
REQ-004 reqA  input  1  requester A wants the resource; held high until grantA is seen or the requester withdraws.
REQ-005 reqB  input  1  requester B wants the resource, same rules as reqA.
REQ-006 doneA  input  1  A releases its grant; sampled only while grantA=1, ignored otherwise.
REQ-007 doneB  input  1  B releases its grant; sampled only while grantB=1, ignored otherwise.
REQ-008 grantA  output  1  registered; A owns the resource.
REQ-009 grantB  output  1  registered; B owns the resource.
REQ-010 prio  output  1  registered round-robin pointer; 0 = A wins the next tie, 1 = B wins the next tie.
REQ-011 preempt  output  1  registered one-cycle pulse; the current grant was revoked by the hold limit.

Function
REQ-012 grantA and grantB are never high in the same cycle.
REQ-013 The FSM has exactly three states: IDLE, OWN_A and OWN_B; grantA=1 only in OWN_A, and grantB=1 only in OWN_B.
REQ-014 IDLE: reqA only -> OWN_A next cycle; reqB only -> OWN_B next cycle; neither -> stay in IDLE.
REQ-015 IDLE with reqA and reqB both high -> OWN_A if prio=0, OWN_B if prio=1.
REQ-016 Grant latency is exactly one cycle from a sampled request in IDLE to the grant output going high.
REQ-017 On entry to OWN_A, prio becomes 1; on entry to OWN_B, prio becomes 0.
REQ-018 OWN_A exits to IDLE on doneA=1 or reqA=0, whichever is sampled first; OWN_B exits symmetrically on doneB=1 or reqB=0.
REQ-019 After any exit, the next cycle is always IDLE; a grant never passes directly from A to B, giving one idle cycle of separation.
REQ-020 Hold counter: 4 bits; cleared on state entry; increments each cycle the owner is held while the other side requests; otherwise holds its value.
REQ-021 When the hold counter reaches MAX_HOLD and the owner has not released: go to IDLE and pulse preempt=1 for that one transition cycle.
REQ-022 After a preempt, prio already points at the other side, so the waiting requester wins the following IDLE arbitration.
REQ-023 A release (done or req drop) in the same cycle as the hold limit counts as a normal release; preempt stays 0.
REQ-024 The hold counter saturates and never wraps; worst-case wait for either requester is MAX_HOLD+2 cycles.
REQ-025 done asserted without an active grant has no effect on state, counter or outputs.

Reset
REQ-026 While reset=0: state=IDLE, grantA=0, grantB=0, prio=0, preempt=0, hold counter=0.
REQ-027 Reset asserted mid-grant drops the grant asynchronously; after release, the first arbitration uses prio=0.
REQ-028 Release of reset is synchronous to clk; the first arbitration takes place on the first posedge with reset=1.

Verification
REQ-029 Reset, then reqA=1 only -> grantA=1 one cycle later, prio=1; doneA=1 -> grantA=0 next cycle, state IDLE.
REQ-030 reqA=reqB=1 from reset (prio=0) -> grantA first; with A holding and B waiting, MAX_HOLD=4 -> preempt pulse, one IDLE cycle, then grantB=1.
REQ-031 Continuous reqA=reqB=1 with immediate done on each grant -> grants alternate A, B, A, B, each separated by one IDLE cycle.
REQ-032 doneA asserted in the same cycle the hold counter hits MAX_HOLD -> grantA=0, preempt=0.
REQ-033 reset driven low during OWN_B -> grantB=0 with no clock edge; after release with reqA=reqB=1 -> grantA wins.
REQ-034 All runs: assertions that grantA and grantB are never both high, preempt lasts exactly one cycle, and no request waits longer than MAX_HOLD+2 cycles.
